word_enc_qh26: RTL and testbench

//  Montgomery-domain entry converter: y = x * 2^R mod q, with R = Q_LEN-TL_LEN and q = {qH, R'b0} | 1.

---
 rtl/word_enc_qh26_pkg.sv | 20 ++
 rtl/word_enc_qh26_if.sv | 35 +++
 rtl/word_enc_qh26_dbl_sub.sv | 17 +
 rtl/word_enc_qh26.sv | 104 ++++++++++
 tb/tb_word_enc_qh26.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/word_enc_qh26_pkg.sv
// Shared types and helpers for the Montgomery entry converter.
package monty_pkg;

  localparam int Q_LEN_D  = 64;
  localparam int TL_LEN_D = 26;
  localparam int R        = Q_LEN_D - TL_LEN_D;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  function automatic logic [Q_LEN_D-1:0] mk_q(
    input logic [TL_LEN_D-1:0] qh
  );
    return {qh, {R{1'b0}}} | Q_LEN_D'(1);
  endfunction

endpackage

// File: rtl/word_enc_qh26_if.sv
// Operand/result handshake bundle for word_enc_qh26.
interface word_enc_qh26_if #(
  parameter int Q_LEN  = 64,
  parameter int TL_LEN = 26
);

  logic [TL_LEN-1:0] qH;
  logic [Q_LEN-1:0]  x_data;
  logic              x_valid;
  logic              x_ready;
  logic [Q_LEN-1:0]  y_data;
  logic              y_valid;
  logic              y_ready;

  modport master (
    output qH,
    output x_data,
    output x_valid,
    input  x_ready,
    input  y_data,
    input  y_valid,
    output y_ready
  );

  modport slave (
    input  qH,
    input  x_data,
    input  x_valid,
    output x_ready,
    output y_data,
    output y_valid,
    input  y_ready
  );

endinterface

// File: rtl/word_enc_qh26_dbl_sub.sv
// One combinational modular doubling: y = 2a mod q, for a < q.
module monty_dbl_sub #(
  parameter int W = 64
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] q_i,
  output logic [W-1:0] y_o
);

  logic [W:0] t;
  logic [W:0] qx;

  assign t   = {a_i, 1'b0};
  assign qx  = {1'b0, q_i};
  assign y_o = (t >= qx) ? W'(t - qx) : W'(t);

endmodule

// File: rtl/word_enc_qh26.sv
// Montgomery entry converter y = x*2^R mod q, one doubling per step.
// `WORD_ENC_RADIX4_EN chains two doublings per cycle (R must be even).
module word_enc_qh26
  import monty_pkg::*;
#(
  parameter int Q_LEN  = 64,
  parameter int TL_LEN = 26,
  parameter bit FF_OUT = 1'b1
) (
  input logic clk,
  input logic rst,
  word_enc_qh26_if.slave bus
);

  localparam int RL = Q_LEN - TL_LEN;
`ifdef WORD_ENC_RADIX4_EN
  localparam int STEPS = RL / 2;
`else
  localparam int STEPS = RL;
`endif
  localparam int CW = (STEPS > 1) ? $clog2(STEPS) : 1;

  state_e            state_q;
  logic [Q_LEN-1:0]  acc_q;
  logic [Q_LEN-1:0]  acc_d;
  logic [Q_LEN-1:0]  q_q;
  logic [CW-1:0]     cnt_q;
  logic              x_ready_q;
  logic              y_valid_q;
  logic [Q_LEN-1:0]  y_data_q;

`ifdef WORD_ENC_RADIX4_EN
  if (RL % 2 != 0) begin : g_odd_r
    $error("word_enc_qh26: radix-4 mode needs even R");
  end

  logic [Q_LEN-1:0] mid;

  monty_dbl_sub #(.W(Q_LEN)) u_dbl0 (
    .a_i (acc_q),
    .q_i (q_q),
    .y_o (mid)
  );

  monty_dbl_sub #(.W(Q_LEN)) u_dbl1 (
    .a_i (mid),
    .q_i (q_q),
    .y_o (acc_d)
  );
`else
  monty_dbl_sub #(.W(Q_LEN)) u_dbl0 (
    .a_i (acc_q),
    .q_i (q_q),
    .y_o (acc_d)
  );
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      q_q       <= '0;
      cnt_q     <= '0;
      x_ready_q <= 1'b1;
      y_valid_q <= 1'b0;
      y_data_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.x_valid) begin
            acc_q     <= bus.x_data;
            q_q       <= {bus.qH, {RL{1'b0}}} | Q_LEN'(1);
            cnt_q     <= '0;
            x_ready_q <= 1'b0;
            state_q   <= RUN;
          end
        end
        RUN: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(STEPS - 1)) begin
            y_data_q  <= acc_d;
            y_valid_q <= 1'b1;
            state_q   <= DONE;
          end
        end
        DONE: begin
          if (bus.y_ready) begin
            y_valid_q <= 1'b0;
            x_ready_q <= 1'b1;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // acc is untouched until the next accept, so both output modes hold y_data
  assign bus.y_data  = FF_OUT ? y_data_q : acc_q;
  assign bus.y_valid = y_valid_q;
  assign bus.x_ready = x_ready_q;

endmodule

// File: tb/tb_word_enc_qh26.sv
// Self-checking bench for word_enc_qh26: vector table, corner
// sequences and random operands against a wide-arithmetic model.
module tb_word_enc_qh26;
  import monty_pkg::*;

  localparam int RB = 38;
`ifdef WORD_ENC_RADIX4_EN
  localparam int STEPS = RB / 2;
`else
  localparam int STEPS = RB;
`endif
  localparam logic [25:0] QH0 = 26'h2000046;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  word_enc_qh26_if #(.Q_LEN(64), .TL_LEN(26)) bus ();

  word_enc_qh26 #(.Q_LEN(64), .TL_LEN(26), .FF_OUT(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [63:0] x;
    logic [63:0] y;
  } vec_t;

  vec_t vecs[5];

  function automatic logic [63:0] ref_enc(
    input logic [63:0] x,
    input logic [25:0] qh
  );
    logic [127:0] q;
    logic [127:0] w;
    q = {64'd0, qh, 38'd0} + 128'd1;
    w = ({64'd0, x} * (128'd1 << RB)) % q;
    return w[63:0];
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (bus.y_valid !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_op(input logic [63:0] x, input logic [25:0] qh,
                        input string nm, output logic [63:0] y);
    int lat;
    @(posedge clk); #1;
    bus.x_valid = 1'b1;
    bus.x_data  = x;
    bus.qH      = qh;
    @(posedge clk); #1;
    bus.x_valid = 1'b0;
    bus.qH      = ~qh;
    bus.x_data  = {$urandom, $urandom};
    chk({nm, " x_ready busy"}, 64'(bus.x_ready), 64'd0);
    wait_valid(lat);
    chk({nm, " latency"}, 64'(lat), 64'(STEPS));
    y = bus.y_data;
    bus.y_ready = 1'b1;
    @(posedge clk); #1;
    bus.y_ready = 1'b0;
    chk({nm, " y_valid drop"}, 64'(bus.y_valid), 64'd0);
    chk({nm, " x_ready back"}, 64'(bus.x_ready), 64'd1);
    chk({nm, " y_data held"}, bus.y_data, y);
  endtask

  initial begin
    logic [63:0] y;
    logic [63:0] x;
    logic [63:0] q;
    logic [25:0] qh;
    int          lat;
    int          seen;

    vecs[0] = '{64'h0, 64'h0};
    vecs[1] = '{64'h1, 64'h0000004000000000};
    vecs[2] = '{64'h2, 64'h0000008000000000};
    vecs[3] = '{64'h0000000002000000, 64'h8000000000000000};
    vecs[4] = '{64'h8000118000000000, 64'h8000114000000001};

    bus.qH      = QH0;
    bus.x_data  = '0;
    bus.x_valid = 1'b0;
    bus.y_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset x_ready", 64'(bus.x_ready), 64'd1);
    chk("reset y_valid", 64'(bus.y_valid), 64'd0);
    chk("reset y_data", bus.y_data, 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      run_op(vecs[i].x, QH0, $sformatf("vec%0d", i), y);
      chk($sformatf("vec%0d y", i), y, vecs[i].y);
    end

    // backpressure with an operand waiting during DONE
    @(posedge clk); #1;
    bus.x_valid = 1'b1;
    bus.x_data  = 64'd5;
    bus.qH      = QH0;
    @(posedge clk); #1;
    bus.x_data  = 64'd2;
    wait_valid(lat);
    chk("bp latency", 64'(lat), 64'(STEPS));
    y = bus.y_data;
    chk("bp y", y, ref_enc(64'd5, QH0));
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp y_valid hold", 64'(bus.y_valid), 64'd1);
      chk("bp y_data hold", bus.y_data, y);
      chk("bp x_ready low", 64'(bus.x_ready), 64'd0);
    end
    bus.y_ready = 1'b1;
    @(posedge clk); #1;
    bus.y_ready = 1'b0;
    chk("bp idle y_valid", 64'(bus.y_valid), 64'd0);
    chk("bp idle x_ready", 64'(bus.x_ready), 64'd1);
    @(posedge clk); #1;
    bus.x_valid = 1'b0;
    chk("bp accept", 64'(bus.x_ready), 64'd0);
    wait_valid(lat);
    chk("bp2 latency", 64'(lat), 64'(STEPS));
    chk("bp2 y", bus.y_data, ref_enc(64'd2, QH0));
    bus.y_ready = 1'b1;
    @(posedge clk); #1;
    bus.y_ready = 1'b0;

    run_op(64'd7, QH0, "b2b0", y);
    chk("b2b0 y", y, ref_enc(64'd7, QH0));
    run_op(64'h123456789, QH0, "b2b1", y);
    chk("b2b1 y", y, ref_enc(64'h123456789, QH0));

    // reset in the middle of RUN
    @(posedge clk); #1;
    bus.x_valid = 1'b1;
    bus.x_data  = 64'h8000118000000000;
    bus.qH      = QH0;
    @(posedge clk); #1;
    bus.x_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst mid x_ready", 64'(bus.x_ready), 64'd1);
    chk("rst mid y_valid", 64'(bus.y_valid), 64'd0);
    chk("rst mid y_data", bus.y_data, 64'd0);
    seen = 0;
    for (int i = 0; i < STEPS + 5; i++) begin
      @(posedge clk); #1;
      if (bus.y_valid === 1'b1) seen++;
    end
    chk("rst mid no pulse", 64'(seen), 64'd0);
    run_op(64'd1, QH0, "post rst", y);
    chk("post rst y", y, 64'h0000004000000000);
    chk("mk_q", mk_q(QH0), 64'h8000118000000001);

    for (int i = 0; i < 1000; i++) begin
      qh = (i % 2 == 0) ? QH0 : (26'($urandom) | 26'h1);
      q  = {qh, 38'd0} | 64'd1;
      x  = {$urandom, $urandom};
      if (x >= q) x = x % q;
      run_op(x, qh, "rand", y);
      chk("rand y", y, ref_enc(x, qh));
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
